mac_start_mult: RTL and testbench

MAC_START_MULT -- requirements
Module: mac_start_mult

---
 rtl/mac_start_mult.sv | 155 +++++++++++++++
 tb/tb_mac_start_mult.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_start_mult.sv
// Walks the i/j/k index space of C = A x B, issuing one A/B read pair per cycle, and emits
// a registered product with pipeline-aligned indices for a downstream accumulator.
module mac_start_mult #(
    parameter int unsigned M                      = 4,
    parameter int unsigned K                      = 4,
    parameter int unsigned N                      = 4,
    parameter int unsigned DATA_WIDTH_INIT_MATRIX = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_in_b,
    output logic [$clog2(M)-1:0]                row_addr_a,
    output logic [$clog2(K)-1:0]                col_addr_a,
    output logic [$clog2(K)-1:0]                row_addr_b,
    output logic [$clog2(N)-1:0]                col_addr_b,
    output logic                                matrix_a_re,
    output logic                                matrix_b_re,
    output logic [2*DATA_WIDTH_INIT_MATRIX-1:0] product_reg,
    output logic [$clog2(M)-1:0]                matrix_a_row_addr_counter_reg,
    output logic [$clog2(K)-1:0]                matrix_a_col_addr_counter_reg,
    output logic [$clog2(K)-1:0]                matrix_b_row_addr_counter_reg,
    output logic [$clog2(N)-1:0]                matrix_b_col_addr_counter_reg,
    output logic                                mult_done_reg,
    output logic                                busy,
    output logic                                done
);

    localparam int unsigned MW = $clog2(M);
    localparam int unsigned KW = $clog2(K);
    localparam int unsigned NW = $clog2(N);
    localparam int unsigned PW = 2 * DATA_WIDTH_INIT_MATRIX;

    if (M < 2 || (M & (M - 1)) != 0 || K < 2 || (K & (K - 1)) != 0 ||
        N < 2 || (N & (N - 1)) != 0) begin : g_param_check
        $error("M, K and N must be powers of two >= 2");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [MW-1:0]   r_i;
    logic [NW-1:0]   r_j;
    logic [KW-1:0]   r_k;
    logic            w_run;
    logic            w_last;
    logic            w_k_wrap;
    logic            w_j_wrap;

    // Stage 1: indices of the read pair whose data arrives this cycle
    logic            r_v1;
    logic [MW-1:0]   r_ai1;
    logic [KW-1:0]   r_ak1;
    logic [KW-1:0]   r_bk1;
    logic [NW-1:0]   r_bj1;

    logic [PW-1:0]   r_product;
    logic [MW-1:0]   r_ai2;
    logic [KW-1:0]   r_ak2;
    logic [KW-1:0]   r_bk2;
    logic [NW-1:0]   r_bj2;
    logic            r_mult_done;

    assign w_run    = (r_state == StRun);
    assign w_k_wrap = (r_k == KW'(K - 1));
    assign w_j_wrap = (r_j == NW'(N - 1));
    assign w_last   = w_k_wrap && w_j_wrap && (r_i == MW'(M - 1));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StRun;
            StRun:   if (w_last) w_state_next = StDrain;
            // Last product is on the outputs and nothing is left in stage 1
            StDrain: if (r_mult_done && !r_v1) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counters wrap to zero after the final pair, so each pass starts at (0,0,0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (w_run) begin
            r_k <= w_k_wrap ? '0 : r_k + 1'b1;
            if (w_k_wrap) begin
                r_j <= w_j_wrap ? '0 : r_j + 1'b1;
                if (w_j_wrap) begin
                    r_i <= (r_i == MW'(M - 1)) ? '0 : r_i + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1        <= 1'b0;
            r_ai1       <= '0;
            r_ak1       <= '0;
            r_bk1       <= '0;
            r_bj1       <= '0;
            r_product   <= '0;
            r_ai2       <= '0;
            r_ak2       <= '0;
            r_bk2       <= '0;
            r_bj2       <= '0;
            r_mult_done <= 1'b0;
        end else begin
            r_v1        <= w_run;
            r_mult_done <= r_v1;
            if (w_run) begin
                r_ai1 <= r_i;
                r_ak1 <= r_k;
                r_bk1 <= r_k;
                r_bj1 <= r_j;
            end
            if (r_v1) begin
                r_product <= PW'(data_in_a) * PW'(data_in_b);
                r_ai2     <= r_ai1;
                r_ak2     <= r_ak1;
                r_bk2     <= r_bk1;
                r_bj2     <= r_bj1;
            end
        end
    end

    assign row_addr_a                    = r_i;
    assign col_addr_a                    = r_k;
    assign row_addr_b                    = r_k;
    assign col_addr_b                    = r_j;
    assign matrix_a_re                   = w_run;
    assign matrix_b_re                   = w_run;
    assign product_reg                   = r_product;
    assign matrix_a_row_addr_counter_reg = r_ai2;
    assign matrix_a_col_addr_counter_reg = r_ak2;
    assign matrix_b_row_addr_counter_reg = r_bk2;
    assign matrix_b_col_addr_counter_reg = r_bj2;
    assign mult_done_reg                 = r_mult_done;
    assign busy                          = (r_state != StIdle);
    assign done                          = (r_state == StDone);

endmodule

// File: tb/tb_mac_start_mult.sv
// Bench for mac_start_mult: a 2x2x2 and a 4x2x4 instance, each fed by a 1-cycle-latency
// memory, with products and indices scored against a matrix-walk reference model.
module tb_mac_start_mult;

    logic clk = 1'b0;
    logic reset;
    logic start0, start1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Instance 0: M=K=N=2, DW=8
    logic [7:0]  da0, db0;
    logic        ra0_row, ra0_col, rb0_row, rb0_col, re_a0, re_b0;
    logic [15:0] p0;
    logic        ai0, ak0, bk0, bj0, md0, busy0, done0;
    logic [7:0]  mem_a0 [4];
    logic [7:0]  mem_b0 [4];

    // Instance 1: M=4, K=2, N=4, DW=8
    logic [7:0]  da1, db1;
    logic [1:0]  ra1_row, rb1_col, ai1, bj1;
    logic        ra1_col, rb1_row, re_a1, re_b1, ak1, bk1, md1, busy1, done1;
    logic [15:0] p1;
    logic [7:0]  mem_a1 [8];
    logic [7:0]  mem_b1 [8];

    mac_start_mult #(.M(2), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(8)) u0 (
        .clk(clk), .reset(reset), .start(start0), .data_in_a(da0), .data_in_b(db0),
        .row_addr_a(ra0_row), .col_addr_a(ra0_col), .row_addr_b(rb0_row), .col_addr_b(rb0_col),
        .matrix_a_re(re_a0), .matrix_b_re(re_b0), .product_reg(p0),
        .matrix_a_row_addr_counter_reg(ai0), .matrix_a_col_addr_counter_reg(ak0),
        .matrix_b_row_addr_counter_reg(bk0), .matrix_b_col_addr_counter_reg(bj0),
        .mult_done_reg(md0), .busy(busy0), .done(done0)
    );

    mac_start_mult #(.M(4), .K(2), .N(4), .DATA_WIDTH_INIT_MATRIX(8)) u1 (
        .clk(clk), .reset(reset), .start(start1), .data_in_a(da1), .data_in_b(db1),
        .row_addr_a(ra1_row), .col_addr_a(ra1_col), .row_addr_b(rb1_row), .col_addr_b(rb1_col),
        .matrix_a_re(re_a1), .matrix_b_re(re_b1), .product_reg(p1),
        .matrix_a_row_addr_counter_reg(ai1), .matrix_a_col_addr_counter_reg(ak1),
        .matrix_b_row_addr_counter_reg(bk1), .matrix_b_col_addr_counter_reg(bj1),
        .mult_done_reg(md1), .busy(busy1), .done(done1)
    );

    always @(posedge clk) begin
        if (re_a0) da0 <= mem_a0[{ra0_row, ra0_col}];
        if (re_b0) db0 <= mem_b0[{rb0_row, rb0_col}];
        if (re_a1) da1 <= mem_a1[{ra1_row, ra1_col}];
        if (re_b1) db1 <= mem_b1[{rb1_row, rb1_col}];
    end

    logic [28:0] snap0;
    logic [32:0] snap1;
    assign snap0 = {ra0_row, ra0_col, rb0_row, rb0_col, re_a0, re_b0, p0,
                    ai0, ak0, bk0, bj0, md0, busy0, done0};
    assign snap1 = {ra1_row, ra1_col, rb1_row, rb1_col, re_a1, re_b1, p1,
                    ai1, ak1, bk1, bj1, md1, busy1, done1};

    // Observed traffic, stamped with the cycle it was seen in
    logic [15:0] q0_p[$];
    logic [3:0]  q0_idx[$];
    int          q0_pc[$];
    int          q0_done[$];
    logic [3:0]  q0_addr[$];
    int          q0_rec[$];
    logic [15:0] q1_p[$];
    logic [5:0]  q1_idx[$];
    int          q1_done[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (md0) begin
            q0_p.push_back(p0);
            q0_idx.push_back({ai0, ak0, bk0, bj0});
            q0_pc.push_back(cyc);
        end
        if (done0) q0_done.push_back(cyc);
        if (re_a0 && re_b0) begin
            q0_addr.push_back({ra0_row, ra0_col, rb0_row, rb0_col});
            q0_rec.push_back(cyc);
        end
        if (md1) begin
            q1_p.push_back(p1);
            q1_idx.push_back({ai1, ak1, bk1, bj1});
        end
        if (done1) q1_done.push_back(cyc);
    end

    // Reference: C element order i, j, then k, each product A(i,k)*B(k,j) with index (i,k,k,j)
    logic [15:0] e_p0[$];
    logic [3:0]  e_idx0[$];
    logic [15:0] e_p1[$];
    logic [5:0]  e_idx1[$];

    task automatic build_model0();
        e_p0 = {};
        e_idx0 = {};
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                for (int k = 0; k < 2; k++) begin
                    e_p0.push_back(16'(mem_a0[i*2+k]) * 16'(mem_b0[k*2+j]));
                    e_idx0.push_back(4'(i*8 + k*4 + k*2 + j));
                end
    endtask

    task automatic build_model1();
        e_p1 = {};
        e_idx1 = {};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 2; k++) begin
                    e_p1.push_back(16'(mem_a1[i*2+k]) * 16'(mem_b1[k*4+j]));
                    e_idx1.push_back(6'(i*16 + k*8 + k*4 + j));
                end
    endtask

    task automatic clear_q();
        q0_p = {}; q0_idx = {}; q0_pc = {}; q0_done = {}; q0_addr = {}; q0_rec = {};
        q1_p = {}; q1_idx = {}; q1_done = {};
    endtask

    task automatic pulse0();
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
    endtask

    task automatic wait_done0(input int maxc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            if (q0_done.size() != 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run0(output bit ok);
        clear_q();
        pulse0();
        wait_done0(100, ok);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (snap0 !== '0) begin
            failures++;
            $display("FAIL reset_outputs_u0 got=%h want=0", snap0);
        end
        checks++;
        if (snap1 !== '0) begin
            failures++;
            $display("FAIL reset_outputs_u1 got=%h want=0", snap1);
        end
        @(negedge clk) reset = 1'b0;
        clear_q();
        repeat (10) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || q0_p.size() != 0 || q0_done.size() != 0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b prods=%0d dones=%0d want 0/0/0",
                     busy0, q0_p.size(), q0_done.size());
        end
    endtask

    task automatic test_example();
        int exp_p[8] = '{5, 14, 6, 16, 15, 28, 18, 32};
        bit ok;
        mem_a0 = '{8'd1, 8'd2, 8'd3, 8'd4};
        mem_b0 = '{8'd5, 8'd6, 8'd7, 8'd8};
        build_model0();
        run0(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL example_timeout got no done want done within 100 cycles");
        end
        checks++;
        if (q0_p.size() != 8 || q0_rec.size() != 8) begin
            failures++;
            $display("FAIL example_count got prods=%0d reads=%0d want 8/8",
                     q0_p.size(), q0_rec.size());
        end
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (q0_p[n] !== 16'(exp_p[n])) begin
                failures++;
                $display("FAIL example_product[%0d] got=%0d want=%0d", n, q0_p[n], exp_p[n]);
            end
            checks++;
            if (q0_addr[n] !== e_idx0[n]) begin
                failures++;
                $display("FAIL example_addr[%0d] got=%b want=%b", n, q0_addr[n], e_idx0[n]);
            end
        end
        checks++;
        if (q0_pc[7] - q0_pc[0] != 7) begin
            failures++;
            $display("FAIL example_no_bubbles got span=%0d want=7", q0_pc[7] - q0_pc[0]);
        end
        checks++;
        if (q0_done.size() != 1 || q0_done[0] != q0_pc[7] + 1) begin
            failures++;
            $display("FAIL example_done got n=%0d at=%0d want n=1 at=%0d",
                     q0_done.size(), q0_done[0], q0_pc[7] + 1);
        end
    endtask

    task automatic test_latency();
        bit ok;
        mem_a0 = '{8'd1, 8'd2, 8'd3, 8'd4};
        mem_b0 = '{8'd5, 8'd6, 8'd7, 8'd8};
        run0(ok);
        checks++;
        if (!ok || q0_pc[0] - q0_rec[0] != 2) begin
            failures++;
            $display("FAIL latency got=%0d want=2", q0_pc[0] - q0_rec[0]);
        end
        checks++;
        if (q0_idx[0] !== 4'b0000 || q0_idx[1] !== 4'b0110) begin
            failures++;
            $display("FAIL first_indices got=%b,%b want=0000,0110", q0_idx[0], q0_idx[1]);
        end
    endtask

    task automatic test_max_operands();
        bit ok;
        mem_a0 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        mem_b0 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run0(ok);
        checks++;
        if (!ok || q0_p.size() != 8) begin
            failures++;
            $display("FAIL max_count got=%0d want=8", q0_p.size());
        end
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (q0_p[n] !== 16'hFE01) begin
                failures++;
                $display("FAIL max_product[%0d] got=%h want=fe01", n, q0_p[n]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 4; it++) begin
            for (int n = 0; n < 4; n++) begin
                mem_a0[n] = 8'($urandom);
                mem_b0[n] = 8'($urandom);
            end
            build_model0();
            run0(ok);
            checks++;
            if (!ok || q0_p.size() != 8) begin
                failures++;
                $display("FAIL random_count it=%0d got=%0d want=8", it, q0_p.size());
            end
            for (int n = 0; n < 8; n++) begin
                checks++;
                if (q0_p[n] !== e_p0[n] || q0_idx[n] !== e_idx0[n]) begin
                    failures++;
                    $display("FAIL random[%0d.%0d] got=%0d/%b want=%0d/%b", it, n,
                             q0_p[n], q0_idx[n], e_p0[n], e_idx0[n]);
                end
            end
        end
    endtask

    task automatic test_restart_ignored();
        bit ok;
        mem_a0 = '{8'd9, 8'd8, 8'd7, 8'd6};
        mem_b0 = '{8'd2, 8'd3, 8'd4, 8'd5};
        build_model0();
        clear_q();
        pulse0();
        repeat (2) @(negedge clk);
        start0 = 1'b1;
        repeat (2) @(negedge clk);
        start0 = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (done0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        // Hold start through the DONE cycle only; it must not launch a new pass
        start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (!ok || q0_p.size() != 8 || q0_done.size() != 1) begin
            failures++;
            $display("FAIL restart got prods=%0d dones=%0d want 8/1", q0_p.size(),
                     q0_done.size());
        end
        checks++;
        if (busy0 !== 1'b0 || q0_rec.size() != 8) begin
            failures++;
            $display("FAIL start_in_done got busy=%b reads=%0d want 0/8", busy0, q0_rec.size());
        end
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (q0_p[n] !== e_p0[n]) begin
                failures++;
                $display("FAIL restart_product[%0d] got=%0d want=%0d", n, q0_p[n], e_p0[n]);
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        bit ok;
        mem_a0 = '{8'd11, 8'd12, 8'd13, 8'd14};
        mem_b0 = '{8'd21, 8'd22, 8'd23, 8'd24};
        build_model0();
        clear_q();
        pulse0();
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (q0_p.size() >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (!ok || snap0 !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%h reached=%b want=0 reached=1", snap0, ok);
        end
        @(negedge clk) reset = 1'b0;
        clear_q();
        repeat (20) @(negedge clk);
        checks++;
        if (q0_p.size() != 0 || q0_done.size() != 0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_quiet got prods=%0d dones=%0d busy=%b want 0/0/0",
                     q0_p.size(), q0_done.size(), busy0);
        end
        run0(ok);
        checks++;
        if (!ok || q0_p.size() != 8) begin
            failures++;
            $display("FAIL reset_mid_recover got=%0d want=8", q0_p.size());
        end
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (q0_p[n] !== e_p0[n] || q0_idx[n] !== e_idx0[n]) begin
                failures++;
                $display("FAIL recover[%0d] got=%0d/%b want=%0d/%b", n, q0_p[n], q0_idx[n],
                         e_p0[n], e_idx0[n]);
            end
        end
    endtask

    task automatic test_shape_4x2x4();
        bit ok;
        for (int n = 0; n < 8; n++) begin
            mem_a1[n] = 8'($urandom);
            mem_b1[n] = 8'($urandom);
        end
        build_model1();
        clear_q();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (q1_done.size() != 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || q1_p.size() != 32 || q1_done.size() != 1) begin
            failures++;
            $display("FAIL shape_count got prods=%0d dones=%0d want 32/1", q1_p.size(),
                     q1_done.size());
        end
        for (int n = 0; n < 32; n++) begin
            checks++;
            if (q1_p[n] !== e_p1[n] || q1_idx[n] !== e_idx1[n] || q1_idx[n][2] !== 1'(n % 2)) begin
                failures++;
                $display("FAIL shape[%0d] got=%0d/%b want=%0d/%b", n, q1_p[n], q1_idx[n],
                         e_p1[n], e_idx1[n]);
            end
        end
        checks++;
        if (q1_idx[31] !== 6'b111111) begin
            failures++;
            $display("FAIL shape_last_idx got=%b want=111111", q1_idx[31]);
        end
    endtask

    initial begin
        test_reset();
        test_example();
        test_latency();
        test_max_operands();
        test_random();
        test_restart_ignored();
        test_reset_mid_pass();
        test_shape_4x2x4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
